// File: rtl/add4_serial_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
// State encoding and nibble-count derivation are also used by the bench.
package add4_serial_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned nib_count(input int unsigned width);
        return width / 4;
    endfunction

endpackage

// File: rtl/add4.sv
// 4-bit ripple adder with carry-in and carry-out; the shared nibble datapath.
module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    end

endmodule

// File: rtl/add4_serial_ctrl.sv
// WIDTH-bit add/subtract sequenced one nibble per clock through a single add4,
// least-significant nibble first, with the carry registered between nibbles.
module add4_serial_ctrl
    import add4_serial_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    input  logic             op_sub,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB = nib_count(WIDTH);
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [IW+1:0]    base;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             last_nib;

    assign base     = {idx_q, 2'b00};
    assign last_nib = (idx_q == IW'(NIB - 1));

    add4 u_add4 (
        .a    (a_q[base +: 4]),
        .b    (b_q[base +: 4]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1; the +1 rides in as the first carry.
                    a_d     = a_in;
                    b_d     = op_sub ? ~b_in : b_in;
                    carry_d = op_sub ? 1'b1 : cin_in;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end else begin
                    result_d[base +: 4] = nib_sum;
                    carry_d             = nib_cout;
                    idx_d               = idx_q + 1'b1;
                    if (last_nib) begin
                        cout_d  = nib_cout;
                        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (nib_sum[3] != a_q[WIDTH-1]);
                        idx_d   = '0;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign cout     = cout_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_add4_serial_ctrl.sv
// Self-checking bench for add4_serial_ctrl at WIDTH=16: vector table plus
// hand-written abort and mid-operation reset sequences.
module tb_add4_serial_ctrl;
    import add4_serial_ctrl_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB   = nib_count(WIDTH);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             op_sub;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int n_pass;
    int n_total;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        bit               hold_valid;
        logic [WIDTH-1:0] exp_res;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[$];

    add4_serial_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
        .op_sub   (op_sub),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_result"}, 32'(result), 32'h0);
        check({tag, "_cout"}, 32'(cout), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    // Drive operands, accept at E0, then follow the exact cycle-by-cycle timing.
    task automatic run_op(input vec_t v);
        @(negedge clk);
        a_in     = v.a;
        b_in     = v.b;
        cin_in   = v.cin;
        op_sub   = v.sub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!v.hold_valid) in_valid = 1'b0;
        check("e0_busy", 32'(busy), 32'd1);
        check("e0_in_ready", 32'(in_ready), 32'd0);
        for (int k = 1; k <= int'(NIB); k++) begin
            @(posedge clk);
            #1;
            if (k < int'(NIB)) begin
                check("run_busy", 32'(busy), 32'd1);
                check("run_done", 32'(done), 32'd0);
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("done_busy", 32'(busy), 32'd0);
                check("done_in_ready", 32'(in_ready), 32'd0);
                check("result", 32'(result), 32'(v.exp_res));
                check("cout", 32'(cout), 32'(v.exp_cout));
                check("ovf", 32'(ovf), 32'(v.exp_ovf));
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("after_done", 32'(done), 32'd0);
        check("after_in_ready", 32'(in_ready), 32'd1);
        check("result_held", 32'(result), 32'(v.exp_res));
    endtask

    initial begin
        vec_t v;
        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a_in     = 16'hAAAA;
        b_in     = 16'h5555;
        cin_in   = 1'b1;
        op_sub   = 1'b0;
        abort    = 1'b0;

        //                a         b        cin   sub   hold  result    cout  ovf
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0});

        // Reset held two edges with in_valid high: nothing accepted.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", 32'(busy), 32'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Abort at E0+2: back to IDLE, no done, flags untouched.
        @(negedge clk);
        a_in     = 16'h00FF;
        b_in     = 16'h0001;
        cin_in   = 1'b0;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("abort_e0_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_idle", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        // Abort while idle must not matter.
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_idle_noeffect", 32'(in_ready), 32'd1);
        v = '{16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        run_op(v);

        // Reset at E0+2 of an operation.
        @(negedge clk);
        a_in     = 16'h7FFF;
        b_in     = 16'h0001;
        cin_in   = 1'b0;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("midreset_no_done", 32'(done), 32'd0);
        end
        v = '{16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        run_op(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
